deserializer: RTL
=================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter DATA_BITS, default 8, number of payload bits per frame.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sin  input  1  serial line, idle high, synchronous to clk.
REQ-005 data  output  DATA_BITS  last received byte.
REQ-006 valid  output  1  data holds an unconsumed byte.
REQ-007 ack  input  1  consumer takes data in a cycle where valid and ack are both high.
REQ-008 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 overrun  output  1  sticky flag: a byte was dropped; cleared only by rst.

Function
REQ-010 Frame format: one bit per clk cycle, LSB first: start bit (0), DATA_BITS payload bits, stop bit (1); a frame is 10 cycles at the default width.
REQ-011 sin shall be sampled on every rising edge, with no oversampling and no input synchronizer.
REQ-012 FSM states: IDLE, DATA, STOP.
REQ-013 IDLE: a sampled sin of 0 starts a frame, moves to DATA and clears the bit counter; a sampled 1 leaves the FSM in IDLE.
REQ-014 DATA: sin is shifted in from the MSB side each cycle so the first payload bit ends at data[0]; after DATA_BITS samples the FSM moves to STOP.
REQ-015 STOP, sin = 1: the shift register is committed to data and valid is set, both visible the cycle after the stop sample; the FSM returns to IDLE.
REQ-016 STOP, sin = 0: frame_err pulses for exactly one cycle, the byte is discarded, data and valid are unchanged, and the FSM returns to IDLE.
REQ-017 Back-to-back frames: in IDLE, a start bit sampled in the cycle right after STOP shall be accepted, so there are no dead cycles.
REQ-018 Handshake: valid clears on the cycle after valid and ack are both high; ack while valid is low has no effect.
REQ-019 Commit in the same cycle as an accepting ack: the new byte is loaded, valid stays high, and no overrun is flagged.
REQ-020 Commit while valid is high and ack is low: the new byte is dropped, data keeps the old byte, and overrun is set.
REQ-021 The bit counter shall be ceil(log2(DATA_BITS+1)) bits wide, with no wrap within a frame.
REQ-022 Start-to-valid latency is DATA_BITS+2 cycles from the start-bit sample edge.

Reset
REQ-023 When rst is high at a clock edge: FSM to IDLE, bit counter 0, shift register 0, data 0, valid 0, frame_err 0, overrun 0.
REQ-024 rst mid-frame aborts the frame; the next frame is recognised only from a fresh start bit after rst is released.
REQ-025 rst takes priority over all other inputs.

Structure
REQ-026 A shared package shall hold the FSM state type, the idle level constant (1), the start level (0) and the stop level (1), and the serializer shall use the same package.
REQ-027 No sub-module: the FSM, counter and shift register shall be flat in deserializer.
REQ-028 The bench shall pair the existing serializer with this deserializer in loopback.

Verification
REQ-029 Send 0xA5 with ack held high -> data = 0xA5, valid high for 1 cycle, exactly 10 cycles after the start-bit edge.
REQ-030 Send 16 back-to-back frames (0x00..0x0F) with ack high -> each byte received in order, with no frame_err and no overrun.
REQ-031 Send a frame of 0x3C with the stop bit forced to 0 -> frame_err pulses once, valid stays low, and data keeps its prior value.
REQ-032 Send 0x11 then 0x22 with ack held low -> data = 0x11, valid high, overrun = 1; then assert ack -> valid clears.
REQ-033 Assert rst for 1 cycle after the 4th data bit of 0xFF -> no valid; the next frame 0x5A is received correctly.
REQ-034 Hold sin high for 50 cycles -> FSM stays IDLE and all outputs stay at their reset values.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial link: the FSM state type and the line
// levels used by both the serializer and the deserializer.
//   IDLE_LEVEL  : level of the line when no frame is in flight
//   START_LEVEL : level of the start bit that opens a frame
//   STOP_LEVEL  : level of the stop bit that closes a frame
package deserializer_pkg;

  // Frame phases, shared by both ends of the link.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serializer.sv
// Serializer: turns a parallel word into a framed serial stream
// (start bit, DATA_BITS payload bits LSB first, stop bit), one bit per clk.
// A new word is taken whenever start is high while ready is high; ready
// returns in the cycle the stop bit is on the line, so a waiting word goes
// out back-to-back with no idle gap.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request to send din (taken when ready is high)
//   din       : word to send
//   bad_stop  : send this frame with a corrupted (low) stop bit
//   sout      : registered serial output, idle high
//   ready     : serializer can take a new word at the next edge
module serializer
  import deserializer_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 bad_stop,
  output logic                 sout,
  output logic                 ready
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_r;
  state_t               next_state_s;
  logic                 load_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 bad_r;
  logic                 sout_r;

  // Next-state decode; a load happens only from IDLE with a pending request.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = DATA;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      DATA: begin
        if (cnt_r == LAST_BIT) begin
          next_state_s = STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      STOP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Line driver and payload shifter; sout always shows the bit of the
  // phase that was just entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      sout_r  <= IDLE_LEVEL;
      shift_r <= {DATA_BITS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      bad_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            sout_r  <= START_LEVEL;
            shift_r <= din;
            cnt_r   <= {CNT_W{1'b0}};
            bad_r   <= bad_stop;
          end else begin
            sout_r  <= IDLE_LEVEL;
          end
        end
        DATA: begin
          sout_r  <= shift_r[0];
          shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
          cnt_r   <= cnt_r + CNT_ONE;
        end
        STOP:    sout_r <= bad_r ? ~STOP_LEVEL : STOP_LEVEL;
        default: sout_r <= IDLE_LEVEL;
      endcase
    end
  end

  assign sout  = sout_r;
  assign ready = (state_r == IDLE);

endmodule

// File: rtl/deserializer.sv
// Deserializer: recovers framed words from a serial line sampled once per
// clk (no oversampling, no synchronizer). Frame: start bit (0), DATA_BITS
// payload bits LSB first, stop bit (1).
// Ports:
//   clk, rst   : clock, synchronous active-high reset (highest priority)
//   sin        : serial line, idle high
//   data       : last committed word
//   valid      : data holds a word not yet taken by the consumer
//   ack        : consumer takes data in a cycle where valid and ack are high
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overrun    : sticky, set when a finished word had to be dropped
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state_r;
  state_t               next_state_s;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 commit_s;
  logic                 bad_stop_s;
  logic                 take_s;
  logic                 drop_s;

  // Next-state decode plus the stop-bit verdict for the current sample.
  always_comb begin
    next_state_s = state_r;
    commit_s     = 1'b0;
    bad_stop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sin == START_LEVEL) begin
          next_state_s = DATA;
        end else begin
          next_state_s = IDLE;
        end
      end
      DATA: begin
        // The counter shows how many payload bits were already taken.
        if (bit_cnt_r == LAST_BIT) begin
          next_state_s = STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      STOP: begin
        next_state_s = IDLE;
        if (sin == STOP_LEVEL) begin
          commit_s   = 1'b1;
        end else begin
          bad_stop_s = 1'b1;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Consumer handshake and the drop decision: a finished word is lost only
  // if the previous one is still held and is not being taken this cycle.
  always_comb begin
    take_s = valid_r & ack;
    drop_s = commit_s & valid_r & ~ack;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Bit counter and payload shift register; bits enter from the MSB side
  // so the first payload bit ends at position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= {CNT_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (sin == START_LEVEL) begin
            bit_cnt_r <= {CNT_W{1'b0}};
          end
        end
        DATA: begin
          shift_r   <= {sin, shift_r[DATA_BITS-1:1]};
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

  // Output registers: commit, handshake, error pulse and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r      <= {DATA_BITS{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= bad_stop_s;
      if (commit_s && !drop_s) begin
        // Also covers a commit in the same cycle as an accepting ack.
        data_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (take_s) begin
        valid_r <= 1'b0;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule
